// File: rtl/flash_write_scheduler.sv
// flash_write_scheduler: round-robin drain of the sensor FIFOs into the single SPI flash write
// port. Each grant writes up to BURST_LEN words at sequential byte addresses that wrap at
// LIMIT_ADDR. After a stop request the scheduler keeps arbitrating until every FIFO is empty,
// then reports acquisition_done.
// Optional feature: define BURST_HEADER_EN to write a header word {8'hA5, sensor index} at the
// start of every grant. The header uses an address slot but does not count toward BURST_LEN.
module flash_write_scheduler #(
    parameter int unsigned           SENSOR_COUNT = 3,
    parameter int unsigned           DATA_WIDTH   = 16,
    parameter int unsigned           ADDR_WIDTH   = 24,
    parameter int unsigned           BURST_LEN    = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 24'h000000,
    parameter logic [ADDR_WIDTH-1:0] LIMIT_ADDR   = 24'hFFFFFF
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start_acquisition,
    input  logic                               stop_acquisition,
    input  logic [SENSOR_COUNT-1:0]            fifo_empty,
    input  logic [SENSOR_COUNT*DATA_WIDTH-1:0] fifo_data,
    output logic [SENSOR_COUNT-1:0]            fifo_read,
    input  logic                               flash_write_ready,
    output logic                               flash_write_start,
    output logic [DATA_WIDTH-1:0]              flash_write_data,
    output logic [ADDR_WIDTH-1:0]              flash_write_addr,
    output logic [$clog2(SENSOR_COUNT)-1:0]    active_sensor,
    output logic                               acquisition_done
);

    localparam int unsigned IdxW = $clog2(SENSOR_COUNT);
    localparam int unsigned CntW = $clog2(BURST_LEN + 1);
    localparam logic [ADDR_WIDTH:0] Step = (ADDR_WIDTH + 1)'(DATA_WIDTH / 8);
    // Highest address from which a full word still fits below LIMIT_ADDR.
    localparam logic [ADDR_WIDTH:0] WrapThr = {1'b0, LIMIT_ADDR} - Step + (ADDR_WIDTH + 1)'(1);
    localparam logic [CntW-1:0] BurstMax = CntW'(BURST_LEN);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(SENSOR_COUNT - 1);

    typedef enum logic [3:0] {
        StIdle,
        StArb,
`ifdef BURST_HEADER_EN
        StHdr,
`endif
        StPop,
        StCap,
        StWait,
        StWr,
        StFall,
        StRise,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [IdxW-1:0]         ptr_q, ptr_d;
    logic [IdxW-1:0]         grant_q, grant_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    stop_q, stop_d;
    logic                    hdr_pending;
    logic                    found;
    logic [IdxW-1:0]         pick;
    int unsigned             scan_idx;
    logic [ADDR_WIDTH:0]     addr_inc;

`ifdef BURST_HEADER_EN
    logic hdr_q, hdr_d;
    assign hdr_pending = hdr_q;
`else
    assign hdr_pending = 1'b0;
`endif

    // State register and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            addr_q  <= BASE_ADDR;
            data_q  <= '0;
            stop_q  <= 1'b0;
`ifdef BURST_HEADER_EN
            hdr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            stop_q  <= stop_d;
`ifdef BURST_HEADER_EN
            hdr_q   <= hdr_d;
`endif
        end
    end

    // Round-robin search: first non-empty FIFO at or after the pointer, wrapping.
    always_comb begin
        found    = 1'b0;
        pick     = ptr_q;
        scan_idx = 0;
        for (int unsigned k = 0; k < SENSOR_COUNT; k++) begin
            scan_idx = (32'(ptr_q) + k) % SENSOR_COUNT;
            if (!found && !fifo_empty[scan_idx]) begin
                found = 1'b1;
                pick  = IdxW'(scan_idx);
            end
        end
    end

    // Next-state and register-update logic.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        stop_d   = stop_q | stop_acquisition;
        addr_inc = {1'b0, addr_q} + Step;
`ifdef BURST_HEADER_EN
        hdr_d    = hdr_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                // Outside a session stop is ignored unless it arrives together with start.
                stop_d = 1'b0;
                if (start_acquisition) begin
                    state_d = StArb;
                    stop_d  = stop_acquisition;
                    addr_d  = BASE_ADDR;
                    ptr_d   = '0;
                end
            end
            StArb: begin
                if (found) begin
                    grant_d = pick;
                    cnt_d   = '0;
`ifdef BURST_HEADER_EN
                    state_d = StHdr;
`else
                    state_d = StPop;
`endif
                end else if (stop_q) begin
                    state_d = StDone;
                end
            end
`ifdef BURST_HEADER_EN
            StHdr: begin
                data_d  = {8'hA5, (DATA_WIDTH - 8)'(grant_q)};
                hdr_d   = 1'b1;
                state_d = flash_write_ready ? StWr : StWait;
            end
`endif
            StPop: begin
                cnt_d   = cnt_q + CntW'(1);
`ifdef BURST_HEADER_EN
                hdr_d   = 1'b0;
`endif
                state_d = StCap;
            end
            StCap: begin
                data_d  = fifo_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
                state_d = flash_write_ready ? StWr : StWait;
            end
            StWait: begin
                if (flash_write_ready) state_d = StWr;
            end
            StWr: begin
                // Ready may already have dropped by the end of the start cycle.
                state_d = flash_write_ready ? StFall : StRise;
            end
            StFall: begin
                if (!flash_write_ready) state_d = StRise;
            end
            StRise: begin
                if (flash_write_ready) begin
                    addr_d = (addr_inc > WrapThr) ? BASE_ADDR : addr_inc[ADDR_WIDTH-1:0];
                    if ((hdr_pending || cnt_q < BurstMax) && !fifo_empty[grant_q]) begin
                        state_d = StPop;
                    end else begin
                        ptr_d   = (grant_q == LastIdx) ? '0 : grant_q + IdxW'(1);
                        state_d = StArb;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        fifo_read = '0;
        if (state_q == StPop) fifo_read[grant_q] = 1'b1;
        flash_write_start = (state_q == StWr);
        acquisition_done  = (state_q == StDone);
    end

    assign flash_write_data = data_q;
    assign flash_write_addr = addr_q;
    assign active_sensor    = grant_q;

endmodule

// File: tb/tb_flash_write_scheduler.sv
// Bench for flash_write_scheduler: FIFO and flash-controller models, random sessions checked
// against a queue-level model of round-robin bursts and wrapping addresses.
module tb_flash_write_scheduler;

    localparam int SC = 3;
    localparam int DW = 16;
    localparam int AW = 24;
    localparam int BL = 4;
    localparam logic [AW-1:0] BASE = 24'h000000;
    localparam logic [AW-1:0] LIMIT = 24'h000007;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_acquisition = 1'b0;
    logic stop_acquisition = 1'b0;
    logic [SC-1:0] fifo_empty;
    logic [SC*DW-1:0] fifo_data = '0;
    logic [SC-1:0] fifo_read;
    logic flash_write_ready = 1'b1;
    logic flash_write_start;
    logic [DW-1:0] flash_write_data;
    logic [AW-1:0] flash_write_addr;
    logic [1:0] active_sensor;
    logic acquisition_done;

    int vectors = 0;
    int miscompares = 0;

    flash_write_scheduler #(
        .SENSOR_COUNT(SC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL),
        .BASE_ADDR(BASE), .LIMIT_ADDR(LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .start_acquisition(start_acquisition), .stop_acquisition(stop_acquisition),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_read(fifo_read),
        .flash_write_ready(flash_write_ready), .flash_write_start(flash_write_start),
        .flash_write_data(flash_write_data), .flash_write_addr(flash_write_addr),
        .active_sensor(active_sensor), .acquisition_done(acquisition_done)
    );

    always #5 clk = ~clk;

    // FIFO model: storage written by the stimulus, popped with one-cycle read latency.
    logic [DW-1:0] mem [SC][64];
    int wr [SC] = '{default: 0};
    int rd [SC] = '{default: 0};
    int pop_count = 0;
    int bad_pops = 0;

    always_comb begin
        for (int i = 0; i < SC; i++) fifo_empty[i] = (wr[i] == rd[i]);
    end

    always @(negedge clk) begin
        if ($countones(fifo_read) > 1) bad_pops++;
        for (int i = 0; i < SC; i++) begin
            if (fifo_read[i]) begin
                pop_count++;
                if (rd[i] == wr[i]) bad_pops++;
                else begin
                    fifo_data[i*DW +: DW] = mem[i][rd[i] % 64];
                    rd[i]++;
                end
            end
        end
    end

    // Flash controller model: logs each write, stays busy a random time, checks stability.
    bit hold_low = 1'b0;
    bit in_busy = 1'b0;
    int busy_cnt = 0;
    int unstable = 0;
    int dbl_start = 0;
    int log_n = 0;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_data;
    logic [AW-1:0] log_addr [1024];
    logic [DW-1:0] log_data [1024];
    logic [1:0]    log_sens [1024];

    always @(negedge clk) begin
        if (!rst_n) begin
            in_busy = 1'b0;
            flash_write_ready = !hold_low;
        end else if (flash_write_start) begin
            if (in_busy) dbl_start++;
            log_addr[log_n % 1024] = flash_write_addr;
            log_data[log_n % 1024] = flash_write_data;
            log_sens[log_n % 1024] = active_sensor;
            log_n++;
            h_addr = flash_write_addr;
            h_data = flash_write_data;
            in_busy = 1'b1;
            busy_cnt = $urandom_range(4, 0);
            flash_write_ready = 1'b0;
        end else if (in_busy) begin
            if (flash_write_data !== h_data || flash_write_addr !== h_addr) unstable++;
            if (busy_cnt == 0) begin
                in_busy = 1'b0;
                flash_write_ready = !hold_low;
            end else busy_cnt--;
        end else flash_write_ready = !hold_low;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model output: expected write sequence of one session.
    int log_base = 0;
    int exp_n = 0;
    int exp_addr [256];
    logic [DW-1:0] exp_data [256];
    int exp_sens [256];

    function automatic int next_addr(input int a);
        int n = a + DW / 8;
        return (n > int'(LIMIT) - DW / 8 + 1) ? int'(BASE) : n;
    endfunction

    // Session from the current FIFO contents: rotate grants, up to BL words each, until empty.
    task automatic build_expected();
        int left [SC];
        int pos [SC];
        int ptr = 0;
        int g;
        int n;
        int a = int'(BASE);
        exp_n = 0;
        for (int i = 0; i < SC; i++) begin
            left[i] = wr[i] - rd[i];
            pos[i] = rd[i];
        end
        while (left[0] + left[1] + left[2] > 0) begin
            g = -1;
            for (int k = 0; k < SC; k++) if (g < 0 && left[(ptr + k) % SC] > 0) g = (ptr + k) % SC;
`ifdef BURST_HEADER_EN
            exp_addr[exp_n] = a; exp_data[exp_n] = {8'hA5, 8'(g)}; exp_sens[exp_n] = g;
            exp_n++; a = next_addr(a);
`endif
            n = (left[g] < BL) ? left[g] : BL;
            for (int k = 0; k < n; k++) begin
                exp_addr[exp_n] = a; exp_data[exp_n] = mem[g][pos[g] % 64]; exp_sens[exp_n] = g;
                exp_n++; a = next_addr(a); pos[g]++;
            end
            left[g] -= n;
            ptr = (g + 1) % SC;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic push_word(input int s, input logic [DW-1:0] w);
        mem[s][wr[s] % 64] = w;
        wr[s]++;
    endtask

    task automatic flush();
        for (int i = 0; i < SC; i++) wr[i] = rd[i];
    endtask

    task automatic pulse_start(input bit with_stop);
        log_base = log_n;
        start_acquisition = 1'b1;
        stop_acquisition = with_stop;
        tick(1);
        start_acquisition = 1'b0;
        stop_acquisition = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_acquisition = 1'b1;
        tick(1);
        stop_acquisition = 1'b0;
    endtask

    task automatic wait_writes(input int n, output bit to);
        to = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (log_n - log_base >= n) begin
                to = 1'b0;
                break;
            end
            tick(1);
        end
    endtask

    task automatic wait_done(output bit to);
        to = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (acquisition_done === 1'b1) begin
                to = 1'b0;
                break;
            end
            tick(1);
        end
    endtask

    task automatic test_reset();
        bit to;
        int p0;
        do_reset();
        vectors += 6;
        if (fifo_read !== '0) begin miscompares++; $display("FAIL rst_read got %b want 0", fifo_read); end
        if (flash_write_start !== 1'b0) begin miscompares++; $display("FAIL rst_start got %b want 0", flash_write_start); end
        if (flash_write_data !== '0) begin miscompares++; $display("FAIL rst_data got %h want 0", flash_write_data); end
        if (flash_write_addr !== BASE) begin miscompares++; $display("FAIL rst_addr got %h want %h", flash_write_addr, BASE); end
        if (active_sensor !== '0) begin miscompares++; $display("FAIL rst_sensor got %0d want 0", active_sensor); end
        if (acquisition_done !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b want 0", acquisition_done); end
        // Reset in the middle of a burst, right while a non-base write is being started.
        flush();
        for (int k = 0; k < 4; k++) push_word(0, DW'($urandom));
        for (int k = 0; k < 4; k++) push_word(1, DW'($urandom));
        pulse_start(1'b0);
        to = 1'b1;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (flash_write_start === 1'b1 && flash_write_addr !== BASE) begin
                to = 1'b0;
                break;
            end
        end
        vectors++;
        if (to) begin miscompares++; $display("FAIL rst_mid_wait got timeout want second write"); end
        #1 rst_n = 1'b0;
        p0 = pop_count;
        @(posedge clk); #1;
        vectors++;
        if (flash_write_start !== 1'b0) begin miscompares++; $display("FAIL rst_mid_start got %b want 0", flash_write_start); end
        tick(2);
        vectors += 5;
        if (pop_count !== p0) begin miscompares++; $display("FAIL rst_mid_pops got %0d want %0d", pop_count, p0); end
        if (flash_write_addr !== BASE) begin miscompares++; $display("FAIL rst_mid_addr got %h want %h", flash_write_addr, BASE); end
        if (flash_write_data !== '0) begin miscompares++; $display("FAIL rst_mid_data got %h want 0", flash_write_data); end
        if (active_sensor !== '0) begin miscompares++; $display("FAIL rst_mid_sensor got %0d want 0", active_sensor); end
        if (fifo_read !== '0) begin miscompares++; $display("FAIL rst_mid_read got %b want 0", fifo_read); end
        rst_n = 1'b1;
        tick(1);
        flush();
    endtask

    task automatic test_single();
        bit to;
        int b;
        do_reset();
        flush();
        push_word(1, 16'h1111);
        push_word(1, 16'h2222);
        build_expected();
        pulse_start(1'b1);
        wait_done(to);
        b = log_base;
        vectors += 2;
        if (to) begin miscompares++; $display("FAIL single_done got timeout want done"); end
        if (log_n - b !== exp_n) begin miscompares++; $display("FAIL single_count got %0d want %0d", log_n - b, exp_n); end
        // Last two writes are the data words regardless of header mode.
        vectors += 6;
        if (log_addr[(log_n-2) % 1024] !== 24'(exp_n - 2) * 2) begin miscompares++; $display("FAIL single_addr0 got %h", log_addr[(log_n-2) % 1024]); end
        if (log_addr[(log_n-1) % 1024] !== 24'(exp_n - 1) * 2) begin miscompares++; $display("FAIL single_addr1 got %h", log_addr[(log_n-1) % 1024]); end
        if (log_data[(log_n-2) % 1024] !== 16'h1111) begin miscompares++; $display("FAIL single_data0 got %h want 1111", log_data[(log_n-2) % 1024]); end
        if (log_data[(log_n-1) % 1024] !== 16'h2222) begin miscompares++; $display("FAIL single_data1 got %h want 2222", log_data[(log_n-1) % 1024]); end
        if (log_sens[(log_n-1) % 1024] !== 2'd1) begin miscompares++; $display("FAIL single_sensor got %0d want 1", log_sens[(log_n-1) % 1024]); end
        if (bad_pops !== 0) begin miscompares++; $display("FAIL single_bad_pops got %0d want 0", bad_pops); end
    endtask

    task automatic test_round_robin();
        bit to;
        bit stop_first;
        int b;
        for (int it = 0; it < 10; it++) begin
            do_reset();
            flush();
            for (int s = 0; s < SC; s++) begin
                int cnt = (it == 0) ? 6 : int'($urandom_range(7, 0));
                for (int k = 0; k < cnt; k++) push_word(s, (it == 0) ? DW'(s * 16 + k) : DW'($urandom));
            end
            build_expected();
            stop_first = (it == 0) ? 1'b1 : 1'($urandom_range(1, 0));
            pulse_start(stop_first);
            if (!stop_first) begin
                wait_writes(exp_n, to);
                vectors++;
                if (to) begin miscompares++; $display("FAIL rr_writes it%0d got %0d want %0d", it, log_n - log_base, exp_n); end
                pulse_stop();
            end
            wait_done(to);
            b = log_base;
            vectors += 2;
            if (to) begin miscompares++; $display("FAIL rr_done it%0d got timeout want done", it); end
            if (log_n - b !== exp_n) begin miscompares++; $display("FAIL rr_count it%0d got %0d want %0d", it, log_n - b, exp_n); end
            for (int k = 0; k < exp_n; k++) begin
                vectors++;
                if (log_addr[(b+k) % 1024] !== AW'(exp_addr[k]) || log_data[(b+k) % 1024] !== exp_data[k]
                    || log_sens[(b+k) % 1024] !== 2'(exp_sens[k])) begin
                    miscompares++;
                    $display("FAIL rr_write it%0d #%0d got a=%h d=%h s=%0d want a=%h d=%h s=%0d", it, k,
                             log_addr[(b+k) % 1024], log_data[(b+k) % 1024], log_sens[(b+k) % 1024],
                             exp_addr[k], exp_data[k], exp_sens[k]);
                end
            end
`ifndef BURST_HEADER_EN
            if (it == 0) begin
                // Grant order 0(4),1(4),2(4),0(2),1(2),2(2).
                for (int k = 0; k < 18; k++) begin
                    vectors++;
                    if (log_sens[(b+k) % 1024] !== 2'((k < 12) ? k / 4 : (k - 12) / 2)) begin
                        miscompares++;
                        $display("FAIL rr_order #%0d got %0d", k, log_sens[(b+k) % 1024]);
                    end
                end
            end
`endif
        end
        vectors += 3;
        if (bad_pops !== 0) begin miscompares++; $display("FAIL rr_bad_pops got %0d want 0", bad_pops); end
        if (unstable !== 0) begin miscompares++; $display("FAIL rr_unstable got %0d want 0", unstable); end
        if (dbl_start !== 0) begin miscompares++; $display("FAIL rr_long_start got %0d want 0", dbl_start); end
    endtask

    task automatic test_back_pressure();
        bit to;
        int p0;
        logic [DW-1:0] want_hold;
        int want_pops;
`ifdef BURST_HEADER_EN
        want_hold = {8'hA5, 8'd2};
        want_pops = 0;
`else
        want_hold = 16'hBEEF;
        want_pops = 1;
`endif
        do_reset();
        flush();
        hold_low = 1'b1;
        push_word(2, 16'hBEEF);
        push_word(2, 16'hCAFE);
        tick(2);
        p0 = pop_count;
        pulse_start(1'b0);
        tick(5);
        for (int c = 0; c < 20; c++) begin
            vectors += 4;
            if (flash_write_start !== 1'b0) begin miscompares++; $display("FAIL bp_start c%0d got %b want 0", c, flash_write_start); end
            if (flash_write_data !== want_hold) begin miscompares++; $display("FAIL bp_data c%0d got %h want %h", c, flash_write_data, want_hold); end
            if (flash_write_addr !== BASE) begin miscompares++; $display("FAIL bp_addr c%0d got %h want %h", c, flash_write_addr, BASE); end
            if (pop_count - p0 !== want_pops) begin miscompares++; $display("FAIL bp_pops c%0d got %0d want %0d", c, pop_count - p0, want_pops); end
            tick(1);
        end
        hold_low = 1'b0;
        build_expected();
        wait_writes(want_pops == 1 ? 2 : 3, to);
        pulse_stop();
        wait_done(to);
        vectors += 2;
        if (to) begin miscompares++; $display("FAIL bp_done got timeout want done"); end
        if (log_data[(log_n-1) % 1024] !== 16'hCAFE) begin miscompares++; $display("FAIL bp_last got %h want cafe", log_data[(log_n-1) % 1024]); end
    endtask

    task automatic test_wrap();
        bit to;
        int b;
        do_reset();
        flush();
        for (int k = 0; k < 5; k++) push_word(0, DW'(16'h5000 + k));
        pulse_start(1'b1);
        wait_done(to);
        b = log_base;
        vectors += 3;
        if (to) begin miscompares++; $display("FAIL wrap_done got timeout want done"); end
        if (log_addr[(b+3) % 1024] !== 24'h000006) begin miscompares++; $display("FAIL wrap_addr3 got %h want 000006", log_addr[(b+3) % 1024]); end
        if (log_addr[(b+4) % 1024] !== 24'h000000) begin miscompares++; $display("FAIL wrap_addr4 got %h want 000000", log_addr[(b+4) % 1024]); end
    endtask

    task automatic test_stop();
        bit to;
        int b;
        do_reset();
        flush();
        for (int k = 0; k < 3; k++) push_word(2, DW'($urandom));
        build_expected();
        pulse_start(1'b0);
        tick(2);
        pulse_stop();
        wait_done(to);
        b = log_base;
        vectors += 2;
        if (to) begin miscompares++; $display("FAIL stop_done got timeout want done"); end
        if (log_n - b !== exp_n) begin miscompares++; $display("FAIL stop_count got %0d want %0d", log_n - b, exp_n); end
        for (int k = 0; k < exp_n; k++) begin
            vectors++;
            if (log_data[(b+k) % 1024] !== exp_data[k]) begin
                miscompares++;
                $display("FAIL stop_data #%0d got %h want %h", k, log_data[(b+k) % 1024], exp_data[k]);
            end
        end
        tick(5);
        vectors++;
        if (acquisition_done !== 1'b1) begin miscompares++; $display("FAIL stop_level got %b want 1", acquisition_done); end
        // Restart from DONE clears done; the new session only finishes after its own stop.
        pulse_start(1'b0);
        tick(3);
        vectors++;
        if (acquisition_done !== 1'b0) begin miscompares++; $display("FAIL restart_clear got %b want 0", acquisition_done); end
        pulse_stop();
        wait_done(to);
        vectors++;
        if (to) begin miscompares++; $display("FAIL restart_done got timeout want done"); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_wrap();
        test_stop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
